// File: rtl/aud_btm_capture.sv
// AUD branch-trace capture: frames AUD nibble-bus branch addresses into a FIFO.
// Optional AUD_TIMESTAMP_EN adds a free-running counter and an out_ts port.
module aud_btm_capture #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                     aud_ck,
  input  logic                     rst,
  input  logic [3:0]               aud_data,
  input  logic                     aud_nsync,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [1:0]               out_len,
  output logic                     out_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              ovf_cnt,
  input  logic                     ovf_clr
`ifdef AUD_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]          out_ts
`endif
);

  localparam int NIBS = ADDR_W / 4;
  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = PW + 1;

  if (!(ADDR_W == 32 || ADDR_W == 64) || DEPTH < 2 || DEPTH > 256 ||
      (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_cfg_check
    $error("aud_btm_capture: illegal parameter set");
  end

  typedef enum logic [1:0] {WAIT_SYNC, IDLE, CAPTURE} state_t;

  state_t              state, state_nx;
  logic [3:0]          cmd;
  logic [4:0]          n;
  logic [ADDR_W-1:0]   nib_buf;
  logic [ADDR_W-1:0]   last_addr;
  logic [ADDR_W-1:0]   merged;

  logic                sup;
  logic [4:0]          exp_n;
  logic [1:0]          len_code;
  logic                frame_end;
  logic                push;
  logic                push_err;
  logic [ADDR_W-1:0]   push_addr;

  logic [ADDR_W-1:0]   mem_addr [DEPTH];
  logic [1:0]          mem_len  [DEPTH];
  logic                mem_err  [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level;
  logic                pop, wr_en, drop;

  // FSM
  always_ff @(posedge aud_ck) begin
    if (rst) state <= WAIT_SYNC;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      WAIT_SYNC: if (aud_nsync)  state_nx = IDLE;
      IDLE:      if (!aud_nsync) state_nx = CAPTURE;
      CAPTURE:   if (aud_nsync)  state_nx = IDLE;
      default:                   state_nx = WAIT_SYNC;
    endcase
  end

  always_comb begin
    sup      = 1'b0;
    exp_n    = 5'd0;
    len_code = 2'd0;
    case (cmd)
      4'b1000: begin sup = 1'b1; exp_n = 5'd1; len_code = 2'd0; end
      4'b1001: begin sup = 1'b1; exp_n = 5'd2; len_code = 2'd1; end
      4'b1010: begin sup = 1'b1; exp_n = 5'd4; len_code = 2'd2; end
      4'b1011: begin sup = 1'b1; exp_n = 5'd8; len_code = 2'd3; end
      4'b1100: if (ADDR_W == 64) begin sup = 1'b1; exp_n = 5'd16; len_code = 2'd3; end
      default: ;
    endcase
  end

  // Received nibbles overwrite only the low exp_n nibbles of the last address.
  always_comb begin
    merged = last_addr;
    for (int unsigned i = 0; i < NIBS; i++)
      if (i < 32'(exp_n)) merged[4*i +: 4] = nib_buf[4*i +: 4];
  end

  assign frame_end = (state == CAPTURE) && aud_nsync;
  assign push      = frame_end && sup;
  assign push_err  = (n != exp_n);
  assign push_addr = push_err ? last_addr : merged;

  always_ff @(posedge aud_ck) begin
    if (rst) begin
      cmd       <= '0;
      n         <= '0;
      nib_buf   <= '0;
      last_addr <= '0;
    end else begin
      if (state != WAIT_SYNC && aud_nsync) cmd <= aud_data;
      if (state == IDLE && !aud_nsync) begin
        nib_buf[3:0] <= aud_data;
        n            <= 5'd1;
      end else if (state == CAPTURE && !aud_nsync) begin
        for (int unsigned i = 0; i < NIBS; i++)
          if (32'(n) == i) nib_buf[4*i +: 4] <= aud_data;
        if (n != 5'd17) n <= n + 5'd1;
      end
      if (push && !push_err) last_addr <= merged;
    end
  end

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign pop   = out_valid && out_ready;
  assign wr_en = push && ((level != LW'(DEPTH)) || pop);
  assign drop  = push && !wr_en;

  always_ff @(posedge aud_ck) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ovf_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      if (ovf_clr)                  ovf_cnt <= drop ? 16'd1 : '0;
      else if (drop && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  always_ff @(posedge aud_ck) begin
    if (wr_en) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_len[wr_ptr]  <= len_code;
      mem_err[wr_ptr]  <= push_err;
    end
  end

  assign out_valid  = (level != '0);
  assign fifo_level = level;
  assign out_addr   = out_valid ? mem_addr[rd_ptr] : '0;
  assign out_len    = out_valid ? mem_len[rd_ptr]  : '0;
  assign out_err    = out_valid ? mem_err[rd_ptr]  : 1'b0;

`ifdef AUD_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_start;
  logic [TS_W-1:0] mem_ts [DEPTH];

  always_ff @(posedge aud_ck) begin
    if (rst) begin
      ts_cnt   <= '0;
      ts_start <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (state == IDLE && !aud_nsync) ts_start <= ts_cnt;
    end
  end

  always_ff @(posedge aud_ck) begin
    if (wr_en) mem_ts[wr_ptr] <= ts_start;
  end

  assign out_ts = out_valid ? mem_ts[rd_ptr] : '0;
`endif

endmodule

// File: doc/aud_btm_capture.md
AUD_BTM_CAPTURE -- requirements
Module: aud_btm_capture

Interface
REQ-001 Parameter ADDR_W, 32, branch address width; legal values 32 or 64.
REQ-002 Parameter DEPTH, 16, output FIFO entries; power of two, 2..256.
REQ-003 Parameter TS_W, 16, timestamp width; used only when AUD_TIMESTAMP_EN is defined.
REQ-004 aud_ck  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 aud_data  in  4  AUD nibble bus; command nibble while aud_nsync=1, address nibble while aud_nsync=0.
REQ-007 aud_nsync  in  1  frame strobe, active low.
REQ-008 out_addr  out  ADDR_W  head-entry branch address.
REQ-009 out_len  out  2  head-entry size code: 0=1, 1=2, 2=4, 3=8 nibbles (3=16 nibbles when ADDR_W=64 and command 4'b1100).
REQ-010 out_err  out  1  head entry is a truncated/overlong frame.
REQ-011 out_valid  out  1  FIFO non-empty.
REQ-012 out_ready  in  1  consumer accept; pop when out_valid & out_ready.
REQ-013 fifo_level  out  $clog2(DEPTH)+1  current entry count.
REQ-014 ovf_cnt  out  16  dropped-entry count, saturating at 16'hFFFF.
REQ-015 ovf_clr  in  1  clears ovf_cnt on the next edge.

Function
REQ-016 The state machine SHALL have states WAIT_SYNC, IDLE and CAPTURE.
REQ-017 WAIT_SYNC: entered on reset; moves to IDLE on the first edge sampling aud_nsync=1; all nibbles are ignored.
REQ-018 IDLE: every edge with aud_nsync=1 loads aud_data into the command register; an edge with aud_nsync=0 moves to CAPTURE and stores that nibble as nibble 0.
REQ-019 CAPTURE: each edge with aud_nsync=0 stores aud_data at nibble index n (LSB first) and increments n; n saturates at 17.
REQ-020 Commands SHALL decode as 4'b1000/1001/1010/1011 = 1/2/4/8 nibbles; 4'b1100 = 16 nibbles only when ADDR_W=64; all other values are unsupported.
REQ-021 Frame end is the first edge in CAPTURE sampling aud_nsync=1; the same edge loads the command register and returns to IDLE.
REQ-022 At frame end with a supported command and n equal to the expected count, the block SHALL merge the nibbles into last_addr: received bits replace the low bits, and upper bits are retained. It SHALL push {merged, len, err=0} and update last_addr.
REQ-023 At frame end with a supported command and n different from the expected count, the block SHALL push {last_addr, len, err=1} and leave last_addr unchanged.
REQ-024 At frame end with an unsupported command, the block SHALL push nothing and leave last_addr unchanged.
REQ-025 Push-to-out_valid latency SHALL be 1 cycle; the head entry appears on out_* in the cycle after the frame-end edge.
REQ-026 A push when fifo_level==DEPTH SHALL drop the entry and increment ovf_cnt, unless a pop occurs on the same edge, in which case the push is accepted.
REQ-027 ovf_clr coincident with an overflow SHALL give ovf_cnt=1.
REQ-028 A pop with out_valid=0 SHALL have no effect; read and write pointers wrap modulo DEPTH.

Reset
REQ-029 On rst the block SHALL enter WAIT_SYNC with last_addr=0, command=0, n=0, FIFO empty (out_valid=0, fifo_level=0), ovf_cnt=0, out_addr=0, out_len=0 and out_err=0.
REQ-030 Reset mid-frame SHALL discard the partial frame; no entry is pushed when aud_nsync subsequently rises.

Configuration
REQ-031 With AUD_TIMESTAMP_EN defined, the block SHALL add a TS_W-bit free-running counter (0 after reset, wraps) and output port out_ts. Each entry carries the counter value sampled on the frame's first address-nibble edge.
REQ-032 Without AUD_TIMESTAMP_EN, out_ts and the counter SHALL be absent and all other behaviour is identical.

Verification
REQ-033 Stimulus: cmd 4'b1011, then nibbles 0..7. Response: one entry with out_addr=32'h76543210, out_len=3, out_err=0.
REQ-034 Stimulus: the REQ-033 frame, then cmd 4'b1010 with nibbles 4,5,6,7. Response: out_addr=32'h76547654, out_len=2.
REQ-035 Stimulus: cmd 4'b1010 with only 3 nibbles. Response: out_err=1 and out_addr equal to the previous address. A following complete 16-bit frame then merges correctly.
REQ-036 Stimulus: hold out_ready=0 and send DEPTH+3 frames. Response: fifo_level=DEPTH and ovf_cnt=3; pop and push on the same edge while full loses nothing.
REQ-037 Stimulus: assert rst during the 5th nibble of a 32-bit frame, starting with aud_nsync low. Response: no entry is pushed, and the first frame after aud_nsync=1 is captured with upper bits 0.
REQ-038 Stimulus: cmd 4'b0011, then 2 nibbles. Response: no entry, and last_addr is unchanged.
